// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Message-granular round-robin arbiter sharing one uart_tx serializer.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 7
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_Byte,
  input  logic [N_REQ-1:0]   i_Last,
  output logic [N_REQ-1:0]   o_Ack,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_TX_DV,
  output logic [7:0]         o_TX_Byte,
  input  logic               i_TX_Active,
  input  logic               i_TX_Done,
  output logic               o_Fault
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(START_TIMEOUT);
  localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_ARB        = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_END   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_IDX_W-1:0]   w_owner_nxt;
  logic [c_IDX_W-1:0]   r_ptr;
  logic [c_IDX_W-1:0]   w_ptr_nxt;
  logic [c_IDX_W-1:0]   w_sel;
  logic [N_REQ-1:0]     r_grant;
  logic [N_REQ-1:0]     w_grant_nxt;
  logic [N_REQ-1:0]     r_ack;
  logic [N_REQ-1:0]     w_ack_nxt;
  logic [N_REQ-1:0]     w_sel_oh;
  logic [N_REQ-1:0]     w_owner_oh;
  logic                 r_dv;
  logic                 w_dv_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic                 r_fault;
  logic                 w_fault_nxt;
  logic                 w_any;
  logic [7:0]           r_tx_byte;
  logic [7:0]           w_tx_byte_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_CNT_W-1:0]   w_cnt_inc;
  logic [7:0]           w_bytes [N_REQ];

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_bytes[g] = i_Byte[8*g +: 8];
    end
  endgenerate

  // Rotating priority: the requester just after the pointer wins.
  always_comb begin
    w_any    = 1'b0;
    w_sel    = '0;
    w_sel_oh = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_any && i_Req[c_IDX_W'((int'(r_ptr) + i) % N_REQ)]) begin
        w_any = 1'b1;
        w_sel = c_IDX_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
    w_sel_oh[w_sel] = w_any;
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_ack_nxt     = '0;
    w_dv_nxt      = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_fault_nxt   = r_fault;
    case (r_state)
      ST_ARB: begin
        if (w_any) begin
          w_owner_nxt = w_sel;
          w_grant_nxt = w_sel_oh;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_Req[r_owner]) begin
          w_dv_nxt      = 1'b1;
          w_ack_nxt     = w_owner_oh;
          w_tx_byte_nxt = w_bytes[r_owner];
          w_last_nxt    = i_Last[r_owner];
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_WAIT_START;
        end else begin
          // Owner walked away mid-message: release without sending.
          w_grant_nxt = '0;
          w_ptr_nxt   = r_owner;
          w_state_nxt = ST_ARB;
        end
      end
      ST_WAIT_START: begin
        if (i_TX_Active) begin
          w_state_nxt = ST_WAIT_END;
        end else if (w_cnt_inc == c_TIMEOUT) begin
          w_fault_nxt = 1'b1;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_owner;
          w_state_nxt = ST_ARB;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_WAIT_END: begin
        // Serializer is idle only once both Active and Done are low together.
        if (!i_TX_Active && !i_TX_Done) begin
          if (r_last) begin
            w_grant_nxt = '0;
            w_ptr_nxt   = r_owner;
            w_state_nxt = ST_ARB;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= ST_ARB;
      r_owner   <= '0;
      r_ptr     <= c_PTR_RST;
      r_grant   <= '0;
      r_ack     <= '0;
      r_dv      <= 1'b0;
      r_tx_byte <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_ack     <= w_ack_nxt;
      r_dv      <= w_dv_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign o_Ack     = r_ack;
  assign o_Grant   = r_grant;
  assign o_TX_DV   = r_dv;
  assign o_TX_Byte = r_tx_byte;
  assign o_Fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed plus randomized bench for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 7;
  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } item_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [8*N-1:0] bytes = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           dv;
  logic [7:0]     txb;
  logic           fault;
  logic           ser_active;
  logic           ser_done;
  logic [7:0]     ser_cnt;
  logic           ser_done_seen;
  bit             ser_en = 1'b1;

  int         n_vec = 0;
  int         n_err = 0;
  item_t      dq [N][$];
  int         rd [N];
  item_t      mq [N][$];
  logic [7:0] dv_log [$];
  logic [7:0] exp_q [$];
  int         exp_ptr = N - 1;
  int         dv_total = 0;
  int         ack_total = 0;
  int         overlap = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TMO)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req       (req),
    .i_Byte      (bytes),
    .i_Last      (last),
    .o_Ack       (ack),
    .o_Grant     (grant),
    .o_TX_DV     (dv),
    .o_TX_Byte   (txb),
    .i_TX_Active (ser_active),
    .i_TX_Done   (ser_done),
    .o_Fault     (fault)
  );

  // Serializer stand-in: 10*CPB cycles Active, then a one-cycle Done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_active    <= 1'b0;
      ser_done      <= 1'b0;
      ser_cnt       <= '0;
      ser_done_seen <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (ser_active) begin
        if (ser_cnt == 0) begin
          ser_active    <= 1'b0;
          ser_done      <= 1'b1;
          ser_done_seen <= 1'b1;
        end else begin
          ser_cnt <= ser_cnt - 1'b1;
        end
      end else if (dv && ser_en && !ser_done) begin
        ser_active <= 1'b1;
        ser_cnt    <= 8'(10*CPB - 1);
      end
    end
  end

  // Requesters: present queue head, advance on Ack.
  initial begin
    for (int k = 0; k < N; k++) rd[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (rst) rd[k] = dq[k].size();
        else if (ack[k]) rd[k] = rd[k] + 1;
        if (!rst && rd[k] < dq[k].size()) begin
          req[k]         = 1'b1;
          bytes[8*k +: 8] = dq[k][rd[k]].b;
          last[k]        = dq[k][rd[k]].l;
        end else begin
          req[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) dv_log.delete();
      if (dv) begin
        dv_log.push_back(txb);
        dv_total = dv_total + 1;
        if (ser_active) overlap = overlap + 1;
      end
      if (ack != '0) ack_total = ack_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_item(input int k, input logic [7:0] b, input logic l);
    item_t it;
    it.b = b;
    it.l = l;
    dq[k].push_back(it);
    mq[k].push_back(it);
  endtask

  // Reference: whole messages handed out round-robin, pointer parked on last owner.
  task automatic model_run();
    int    p;
    int    k;
    item_t it;
    p = exp_ptr;
    forever begin
      k = -1;
      for (int i = 1; i <= N; i++)
        if (k < 0 && mq[(p + i) % N].size() > 0) k = (p + i) % N;
      if (k < 0) break;
      while (mq[k].size() > 0) begin
        it = mq[k].pop_front();
        exp_q.push_back(it.b);
        if (it.l) break;
      end
      p = k;
    end
    exp_ptr = p;
  endtask

  function automatic bit all_idle();
    bit e;
    e = (grant == '0) && !ser_active && !ser_done && !dv;
    for (int k = 0; k < N; k++) if (rd[k] < dq[k].size()) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (!all_idle() && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(all_idle()), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string tag);
    int i;
    i = 0;
    while (grant !== g && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(grant), 32'(g));
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, 32'(dv_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dv_log.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(dv_log[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) mq[k].delete();
    exp_q.delete();
    exp_ptr = N - 1;
    ser_en  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    int base;
    int nm;
    int len;
    bit trunc;

    // Reset values
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dv", 32'(dv), 32'd0);
    check("rst_byte", 32'(txb), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // Single requester: grant, Ack one cycle later, release after Done clears
    push_item(0, 8'hA5, 1'b1);
    wait_grant(4'b0001, "single_grant");
    check("single_ack_early", 32'(ack), 32'd0);
    @(negedge clk);
    check("single_ack", 32'(ack), 32'b0001);
    check("single_dv", 32'(dv), 32'd1);
    check("single_byte", 32'(txb), 32'hA5);
    @(negedge clk);
    check("single_dv_pulse", 32'(dv), 32'd0);
    c = 1;
    while (grant != '0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("single_release_cycles", 32'(c), 32'd43);
    check("single_done_seen", 32'(ser_done_seen), 32'd1);
    check("single_fault", 32'(fault), 32'd0);

    // Round-robin with every byte ending its message
    do_reset();
    push_item(0, 8'h10, 1'b1);
    push_item(1, 8'h11, 1'b1);
    push_item(2, 8'h12, 1'b1);
    push_item(3, 8'h13, 1'b1);
    push_item(0, 8'h10, 1'b1);
    model_run();
    drain("rr_drain");
    compare_log("rr");

    // Message lock: requester 1 joins while requester 2 owns the line
    do_reset();
    push_item(2, 8'h01, 1'b0);
    push_item(2, 8'h02, 1'b0);
    push_item(2, 8'h03, 1'b1);
    wait_grant(4'b0100, "lock_grant");
    push_item(1, 8'hAA, 1'b1);
    exp_q = {8'h01, 8'h02, 8'h03, 8'hAA};
    drain("lock_drain");
    compare_log("lock");

    // Abandon: requester 3 drops Req after a non-final byte
    do_reset();
    base = dv_total;
    push_item(3, 8'h55, 1'b0);
    wait_grant(4'b1000, "abandon_grant");
    c = 0;
    while (grant != '0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    check("abandon_grant_clear", 32'(grant), 32'd0);
    check("abandon_dv_count", 32'(dv_total - base), 32'd1);
    check("abandon_fault", 32'(fault), 32'd0);
    exp_q = {8'h55};
    compare_log("abandon");

    // Start timeout with the serializer never going Active
    do_reset();
    ser_en = 1'b0;
    push_item(0, 8'h77, 1'b1);
    push_item(1, 8'h88, 1'b1);
    c = 0;
    while (!dv && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("tmo_dv_seen", 32'(dv), 32'd1);
    check("tmo_byte0", 32'(txb), 32'h77);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      check($sformatf("tmo_fault_k%0d", k), 32'(fault), 32'(k == TMO));
    end
    check("tmo_grant_clear", 32'(grant), 32'd0);
    ser_en = 1'b1;
    c = 0;
    while (!dv && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("tmo_next_byte", 32'(txb), 32'h88);
    drain("tmo_drain");
    check("tmo_fault_sticky", 32'(fault), 32'd1);

    // Asynchronous reset in WAIT_END, then requester 0 wins first
    do_reset();
    check("tmo_fault_cleared", 32'(fault), 32'd0);
    push_item(0, 8'hC3, 1'b1);
    c = 0;
    while (!ser_active && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (5) @(negedge clk);
    check("midrst_owned", 32'(grant), 32'b0001);
    #2 rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_dv", 32'(dv), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_byte", 32'(txb), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    do_reset();
    push_item(3, 8'hD3, 1'b1);
    push_item(0, 8'hD0, 1'b1);
    exp_q = {8'hD0, 8'hD3};
    drain("midrst_drain");
    compare_log("midrst");

    // Randomized message mixes, some ending in abandonment
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < N; k++) begin
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          len   = $urandom_range(1, 3);
          trunc = (m == nm - 1) && ($urandom_range(0, 5) == 0);
          for (int j = 0; j < len; j++)
            push_item(k, 8'($urandom), (j == len - 1) && !trunc);
        end
      end
      model_run();
      drain($sformatf("rand%0d_drain", r));
      compare_log($sformatf("rand%0d", r));
    end

    check("ack_dv_pairing", 32'(ack_total), 32'(dv_total));
    check("dv_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N_REQ byte sources (e.g. Ethernet debug dump, status reporter, command echo).
- Round-robin arbitration at message granularity: a granted requester keeps the line until it presents a byte flagged last.
- Issues exactly one i_TX_DV per byte and tracks the serializer's Active/Done handshake, so bytes are never dropped or overlapped.
- Sits between the requesters and uart_tx, on the same clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 7, cycles to wait for i_TX_Active after issuing DV before declaring a fault.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  N_REQ  per-requester request; held high while that requester has a byte to send.
- i_Byte  in  8*N_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
- i_Last  in  N_REQ  per-requester flag; high means the current byte ends the message.
- o_Ack  out  N_REQ  one-cycle pulse: the byte of requester k was accepted this cycle.
- o_Grant  out  N_REQ  one-hot current owner; all zero when no owner.
- o_TX_DV  out  1  to uart_tx i_TX_DV.
- o_TX_Byte  out  8  to uart_tx i_TX_Byte; valid when o_TX_DV is high.
- i_TX_Active  in  1  from uart_tx o_TX_Active.
- i_TX_Done  in  1  from uart_tx o_TX_Done.
- o_Fault  out  1  sticky; set on start timeout, cleared only by reset.

Behaviour:
- Reset values (async assert): state ARB, owner none, round-robin pointer = N_REQ-1 (requester 0 gets first priority), o_Ack=0, o_Grant=0, o_TX_DV=0, o_TX_Byte=0, o_Fault=0.
- All outputs are registered.
- ARB state:
  - If any i_Req is high, grant the first requesting index scanning from pointer+1 upward, wrapping.
  - Set o_Grant; go to ISSUE next cycle.
  - If nothing is requested, stay in ARB.
- ISSUE state:
  - If the owner's i_Req is high: assert o_TX_DV and o_Ack[owner] for exactly one cycle, load o_TX_Byte from the owner's i_Byte, latch the owner's i_Last into last_r, clear the timeout counter, go to WAIT_START.
  - If the owner's i_Req is low: abandon the message, clear o_Grant, set pointer = owner, go to ARB. No DV is issued.
- WAIT_START state:
  - i_TX_Active high -> go to WAIT_END.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT: set o_Fault, clear o_Grant, set pointer = owner, go to ARB.
- WAIT_END state: wait until i_TX_Active=0 and i_TX_Done=0 in the same cycle. This guarantees uart_tx has completed its Done/cleanup phase and is back in idle. Then:
  - last_r=1: clear o_Grant, set pointer = owner, go to ARB.
  - last_r=0: go to ISSUE with the same owner.
- Requester contract:
  - A requester samples o_Ack. On the cycle after Ack it presents its next byte, or drops i_Req.
  - i_Byte and i_Last must be stable while i_Req is high and Ack has not yet been given.
- Minimum spacing between DV pulses is one full serializer frame (10*CLKS_PER_BIT cycles) plus at most 3 cycles of overhead.
- No combinational path from i_Req to o_TX_DV. Worst-case grant latency from i_Req to Ack is 2 cycles when the arbiter is idle.
- Requests arriving during WAIT_START or WAIT_END are not considered until the next ARB.
- A requester that drops i_Req mid-message is released at the next ISSUE. No fault is raised.
- Asserting i_Reset mid-frame returns to ARB immediately. The serializer is reset by the same signal in the integrating top.

Test Plan:
- Single requester: CLKS_PER_BIT=4, i_Req[0]=1, Byte=8'hA5, Last=1 -> one DV carrying A5. o_Ack[0] pulses 1 cycle after o_Grant=4'b0001. Grant clears after Active and Done both fall (~40 cycles).
- Round-robin: Req=4'b1111 constant, every Last=1, bytes 8'h10/11/12/13 -> DV order 10, 11, 12, 13, 10. Exactly one DV per frame; no overlap with i_TX_Active.
- Message lock: requester 2 sends 3 bytes 8'h01, 02, 03 with Last only on 03, while requester 1 also requests -> the three bytes go out back-to-back, then the grant moves to requester 1.
- Abandon: requester 3 is granted, sends byte 8'h55 with Last=0, then drops Req -> o_Grant clears at the next ISSUE, no second DV, o_Fault=0.
- Timeout: tie i_TX_Active low, START_TIMEOUT=7 -> o_Fault=1 seven cycles after DV and stays set. Grant clears and the next requester is served.
- Reset mid-frame: pulse i_Reset during WAIT_END -> all outputs 0 asynchronously. The next request from requester 0 is served first.
